// File: rtl/cla_pkg.sv
// Shared types and constants for the arbitrated 16-bit carry look-ahead adder.
package cla_pkg;
    localparam int WIDTH = 16;
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    typedef struct packed {
        logic [WIDTH-1:0] in1;
        logic [WIDTH-1:0] in2;
        logic             c_in;
    } operand_t;

    // Signed overflow: same-sign operands producing a result of the other sign.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction
endpackage

// File: rtl/cla_16bit_lcu.sv
// 16-bit carry look-ahead adder: four 4-bit CLA slices joined by a look-ahead carry unit.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       p,
    output logic       g
);
    logic [3:0] bp, bg;
    logic [3:0] c;

    assign bp = a ^ b;
    assign bg = a & b;

    assign c[0] = c_in;
    assign c[1] = bg[0] | (bp[0] & c_in);
    assign c[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & c_in);
    assign c[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
                | (bp[2] & bp[1] & bp[0] & c_in);

    assign sum = bp ^ c;
    assign p   = &bp;
    assign g   = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
               | (bp[3] & bp[2] & bp[1] & bg[0]);
endmodule

module cla_16bit_lcu
    import cla_pkg::*;
(
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             p,
    output logic             g
);
    localparam int NUM_SLICES = WIDTH / 4;

    logic [NUM_SLICES-1:0] sp, sg;
    logic [NUM_SLICES:0]   c;

    // Slice carries come straight from the group terms, never rippling slice to slice.
    assign c[0] = c_in;
    assign c[1] = sg[0] | (sp[0] & c_in);
    assign c[2] = sg[1] | (sp[1] & sg[0]) | (sp[1] & sp[0] & c_in);
    assign c[3] = sg[2] | (sp[2] & sg[1]) | (sp[2] & sp[1] & sg[0])
                | (sp[2] & sp[1] & sp[0] & c_in);
    assign p    = &sp;
    assign g    = sg[3] | (sp[3] & sg[2]) | (sp[3] & sp[2] & sg[1])
                | (sp[3] & sp[2] & sp[1] & sg[0]);
    assign c[4] = g | (p & c_in);
    assign c_out = c[NUM_SLICES];

    genvar i;
    generate
        for (i = 0; i < NUM_SLICES; i++) begin : g_slice
            cla_4bit u_slice (
                .a   (in1[4*i +: 4]),
                .b   (in2[4*i +: 4]),
                .c_in(c[i]),
                .sum (sum[4*i +: 4]),
                .p   (sp[i]),
                .g   (sg[i])
            );
        end
    endgenerate
endmodule

// File: rtl/cla_adder_arbiter.sv
// Two requesters share one CLA through a round-robin (or fixed) arbiter; the sum lands
// in a single response register that can accept and drain in the same cycle.
module cla_adder_arbiter
    import cla_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_in1,
    input  logic [WIDTH-1:0] req0_in2,
    input  logic             req0_c_in,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_in1,
    input  logic [WIDTH-1:0] req1_in2,
    input  logic             req1_c_in,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_sum,
    output logic             resp_c_out,
    output logic             resp_ovf
);
    logic             free, grant0, grant1, accept, win_id, last_id;
    operand_t         op0, op1, sel;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             lcu_p_unused, lcu_g_unused;

    assign free = !resp_valid || resp_ready;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIO || last_id == REQ1) grant0 = 1'b1;
            else                               grant1 = 1'b1;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // Readys are masked during reset so nothing is lost in the cycle being cleared.
    assign req0_ready = free && grant0 && !rst;
    assign req1_ready = free && grant1 && !rst;
    assign accept     = req0_ready || req1_ready;
    assign win_id     = grant1 ? REQ1 : REQ0;

    assign op0 = {req0_in1, req0_in2, req0_c_in};
    assign op1 = {req1_in1, req1_in2, req1_c_in};
    assign sel = grant1 ? op1 : op0;

    cla_16bit_lcu u_lcu (
        .in1  (sel.in1),
        .in2  (sel.in2),
        .c_in (sel.c_in),
        .sum  (sum),
        .c_out(c_out),
        .p    (lcu_p_unused),
        .g    (lcu_g_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= REQ0;
            resp_sum   <= '0;
            resp_c_out <= 1'b0;
            resp_ovf   <= 1'b0;
            last_id    <= REQ1;
        end else if (accept) begin
            resp_valid <= 1'b1;
            resp_id    <= win_id;
            resp_sum   <= sum;
            resp_c_out <= c_out;
            resp_ovf   <= add_ovf(sel.in1[WIDTH-1], sel.in2[WIDTH-1], sum[WIDTH-1]);
            last_id    <= win_id;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end
endmodule

// File: doc/cla_adder_arbiter.md
# cla_adder_arbiter

Shares one 16-bit carry look-ahead adder between two requesters. Each requester offers an operand pair and carry-in over a valid/ready handshake. A round-robin arbiter (fixed priority optional) picks at most one request per cycle and drives the shared `cla_16bit_lcu` adder. The result is registered into a single response stage with backpressure. The block sits between the two operand-producing units and the shared adder.

## Interface
- `FIXED_PRIO`, default 0: 0 selects round-robin arbitration; 1 makes requester 0 always win.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset; synchronous, active-high.
- `req0_valid`, `req1_valid` input 1 each: request offered.
- `req0_ready`, `req1_ready` output 1 each: request accepted this cycle when valid and ready are both high.
- `req0_in1`, `req0_in2`, `req1_in1`, `req1_in2` input 16 each: unsigned operands.
- `req0_c_in`, `req1_c_in` input 1 each: carry-in.
- `resp_valid` output 1: the response register holds a result.
- `resp_ready` input 1: the consumer takes the result.
- `resp_id` output 1: index of the requester that produced the result.
- `resp_sum` output 16: sum bits.
- `resp_c_out` output 1: carry-out.
- `resp_ovf` output 1: two's-complement overflow.

## Operation
- **Stage free:**
  - `free = !resp_valid || resp_ready`.
  - Arbitration runs every cycle.
  - A grant is issued only when `free` is high.
- **Grant:**
  - Only one valid requester: it wins.
  - Both valid, `FIXED_PRIO=1`: req0 wins.
  - Both valid, `FIXED_PRIO=0`: the requester opposite `last_id` wins.
- **Ready:**
  - `reqN_ready = free && grantN`.
  - This is combinational and depends on `reqN_valid`.
  - Requesters must not make valid depend on ready.
- **On accept:**
  - The granted operands go through a 2:1 mux into the adder.
  - The adder result is captured into the response register.
  - `resp_id` and `last_id` are set to the winner.
- **Overflow:** `resp_ovf = (in1[15]==in2[15]) && (sum[15]!=in1[15])`, computed from the granted operands.
- **Response register state:**
  - Set (`resp_valid` rises) on accept.
  - Cleared on `resp_ready` with no new accept.
  - Accept and drain in the same cycle: the register is overwritten with the new result and `resp_valid` stays 1. This gives a sustained 1 result/cycle.
- **Stall:**
  - `resp_valid && !resp_ready` drives both readys to 0.
  - All response outputs then hold their values.
- **Neither request valid while free:** no grant; `last_id` is unchanged.
- A requester that is valid but not granted keeps its request pending. Round-robin grants it no later than the next cycle in which `free` is high.

## Timing
- **Reset values:**
  - `resp_valid` = 0, `resp_id` = 0, `resp_sum` = 0, `resp_c_out` = 0, `resp_ovf` = 0.
  - `last_id` = 1, so req0 wins the first contention.
- **Latency:** the result appears on the response outputs 1 cycle after the accepting edge.
- **Throughput:** 1 accept per cycle while `resp_ready` stays high.
- **Two-requester contention:** with `resp_ready` high, grants alternate req0, req1, req0, ...
- **`rst` mid-operation:**
  - The pending response is discarded.
  - Outputs return to reset values on that edge.
  - No ready is asserted during the reset cycle.
- **Adder path:** combinational within one cycle, from the mux through the adder to the response register D input.

## Structure
- **Shared package `cla_pkg`:**
  - `WIDTH = 16`.
  - Requester-id constants `REQ0 = 1'b0`, `REQ1 = 1'b1`.
  - Packed operand struct `{in1, in2, c_in}`.
- **Sub-module `cla_16bit_lcu`:** the shared combinational 16-bit CLA, built from 4-bit CLA slices plus a look-ahead carry unit. It exposes `sum`, `c_out`, `p`, `g`; `p` and `g` are left unused here.
- **Arbiter:** a small local always block inside `cla_adder_arbiter`; no separate module.

## Test plan
- **Reset:**
  - Stimulus: hold `rst` 2 cycles, then release with no requests.
  - Required: `resp_valid` = 0, both readys = 0, all outputs 0.
- **Single request:**
  - Stimulus: req0 offers 3745 + 16285 with c_in=0.
  - Required: accepted at edge k; at k+1, `resp_sum` = 20030, `resp_c_out` = 0, `resp_id` = 0, `resp_ovf` = 0.
- **Contention, round-robin:**
  - Stimulus: req0 = 25000 + 40535 with c_in=0; req1 = 25535 + 40000 with c_in=1; both held valid.
  - Required: first result is req0 with sum 65535, c_out 0. Second is req1 with sum 0, c_out 1. Grants then alternate.
- **Backpressure:**
  - Stimulus: `resp_ready` = 0 for 3 cycles while both requests are valid.
  - Required:
    - Both readys = 0 after the first accept.
    - `resp_sum`, `resp_c_out`, `resp_id` and `resp_ovf` stay stable.
    - Once `resp_ready` rises, the held result drains and the waiting requester is accepted in that same cycle.
- **Signed overflow:**
  - Stimulus: 16'h7FFF + 16'h0001 with c_in=0.
  - Required: sum 16'h8000, `resp_ovf` = 1, `resp_c_out` = 0.
- **Fixed priority and reset mid-operation:**
  - Stimulus (`FIXED_PRIO=1`): both requesters held valid.
  - Required: req0 wins every cycle.
  - Stimulus: assert `rst` while `resp_valid` = 1.
  - Required: `resp_valid` = 0 on the next edge.
